// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: registered lookups, saturating counters, round-robin replacement.
// Define BTB_FLUSH_EN to add the flush_/flush_busy ports and the multi-cycle invalidation sweep.
module btb_assoc #(
    parameter int unsigned ADDR     = 32,
    parameter int unsigned BTB_D    = 32,
    parameter int unsigned WAY      = 2,
    parameter int unsigned FETCH    = 1,
    parameter int unsigned SIMBRCOM = 1,
    parameter int unsigned CNT      = 2
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic [FETCH*ADDR-1:0]    btb_addr,
    output logic [FETCH-1:0]         target_valid,
    output logic [FETCH*ADDR-1:0]    target_addr,
    input  logic [SIMBRCOM-1:0]      pc_chg_com_,
    input  logic [SIMBRCOM-1:0]      chg_taken_,
    input  logic [SIMBRCOM*ADDR-1:0] com_addr,
    input  logic [SIMBRCOM*ADDR-1:0] com_tar_addr
`ifdef BTB_FLUSH_EN
    ,
    input  logic                     flush_,
    output logic                     flush_busy
`endif
);

    localparam int unsigned SETS  = BTB_D / WAY;
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR - 2 - IDX_W;
    localparam int unsigned WAY_W = (WAY > 1) ? $clog2(WAY) : 1;
    localparam logic [CNT-1:0] CNT_WEAK = CNT'(1) << (CNT - 1);

    logic [WAY-1:0]   valid_q [SETS];
    logic [WAY-1:0]   valid_d [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAY];
    logic [TAG_W-1:0] tag_d   [SETS][WAY];
    logic [ADDR-1:0]  tgt_q   [SETS][WAY];
    logic [ADDR-1:0]  tgt_d   [SETS][WAY];
    logic [CNT-1:0]   cnt_q   [SETS][WAY];
    logic [CNT-1:0]   cnt_d   [SETS][WAY];
    logic [WAY_W-1:0] rr_q    [SETS];
    logic [WAY_W-1:0] rr_d    [SETS];

    logic [FETCH-1:0]      target_valid_q, target_valid_d;
    logic [FETCH*ADDR-1:0] target_addr_q, target_addr_d;

    logic in_sweep;
    logic hide_lookup;

    logic [IDX_W-1:0]    c_idx      [SIMBRCOM];
    logic [TAG_W-1:0]    c_tag      [SIMBRCOM];
    logic [WAY_W-1:0]    c_hway     [SIMBRCOM];
    logic [WAY_W-1:0]    c_free_way [SIMBRCOM];
    logic [WAY_W-1:0]    c_victim   [SIMBRCOM];
    logic [SIMBRCOM-1:0] c_en, c_hit, c_has_free;

    logic [IDX_W-1:0] l_idx [FETCH];
    logic [TAG_W-1:0] l_tag [FETCH];

    logic unused_low_bits;
    assign unused_low_bits = ^{btb_addr, com_addr};

`ifdef BTB_FLUSH_EN
    typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             flush_busy_q, flush_busy_d;

    // Sweep FSM: one set invalidated per cycle, flush_ ignored while sweeping
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            S_IDLE: begin
                if (!flush_) begin
                    state_d = S_SWEEP;
                    sweep_d = '0;
                end
            end
            S_SWEEP: begin
                sweep_d = IDX_W'(sweep_q + 1'b1);
                if (sweep_q == IDX_W'(SETS - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        flush_busy_d = (state_d == S_SWEEP);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= S_IDLE;
            sweep_q      <= '0;
            flush_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            flush_busy_q <= flush_busy_d;
        end
    end

    assign flush_busy  = flush_busy_q;
    assign in_sweep    = (state_q == S_SWEEP);
    // Also hide the entry and exit cycles so no partially swept set leaks a prediction
    assign hide_lookup = (state_q == S_SWEEP) || (state_d == S_SWEEP);
`else
    assign in_sweep    = 1'b0;
    assign hide_lookup = 1'b0;
`endif

    // Commit decode: set/tag, hit way, allocation victim, same-set arbitration
    always_comb begin
        for (int p = 0; p < SIMBRCOM; p++) begin
            c_idx[p] = com_addr[p*ADDR+2 +: IDX_W];
            c_tag[p] = com_addr[p*ADDR+2+IDX_W +: TAG_W];
        end
        for (int p = 0; p < SIMBRCOM; p++) begin
            c_en[p] = !pc_chg_com_[p] && !in_sweep;
            for (int q = 0; q < SIMBRCOM; q++) begin
                if (q < p && !pc_chg_com_[q] && (c_idx[q] == c_idx[p])) begin
                    c_en[p] = 1'b0;
                end
            end
            c_hit[p]      = 1'b0;
            c_hway[p]     = '0;
            c_has_free[p] = 1'b0;
            c_free_way[p] = '0;
            for (int w = WAY - 1; w >= 0; w--) begin
                if (!valid_q[c_idx[p]][w]) begin
                    c_has_free[p] = 1'b1;
                    c_free_way[p] = WAY_W'(w);
                end
                if (valid_q[c_idx[p]][w] && (tag_q[c_idx[p]][w] == c_tag[p])) begin
                    c_hit[p]  = 1'b1;
                    c_hway[p] = WAY_W'(w);
                end
            end
            c_victim[p] = c_has_free[p] ? c_free_way[p] : rr_q[c_idx[p]];
        end
    end

    // Table update; surviving commit ports always target distinct sets
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        for (int p = 0; p < SIMBRCOM; p++) begin
            if (c_en[p]) begin
                if (!chg_taken_[p]) begin
                    if (c_hit[p]) begin
                        if (cnt_q[c_idx[p]][c_hway[p]] != '1) begin
                            cnt_d[c_idx[p]][c_hway[p]] = CNT'(cnt_q[c_idx[p]][c_hway[p]] + CNT'(1));
                        end
                        tgt_d[c_idx[p]][c_hway[p]] = com_tar_addr[p*ADDR +: ADDR];
                    end else begin
                        if (!c_has_free[p]) begin
                            rr_d[c_idx[p]] = (rr_q[c_idx[p]] == WAY_W'(WAY - 1)) ?
                                             '0 : WAY_W'(rr_q[c_idx[p]] + WAY_W'(1));
                        end
                        valid_d[c_idx[p]][c_victim[p]] = 1'b1;
                        tag_d[c_idx[p]][c_victim[p]]   = c_tag[p];
                        tgt_d[c_idx[p]][c_victim[p]]   = com_tar_addr[p*ADDR +: ADDR];
                        cnt_d[c_idx[p]][c_victim[p]]   = CNT_WEAK;
                    end
                end else if (c_hit[p] && (cnt_q[c_idx[p]][c_hway[p]] != '0)) begin
                    cnt_d[c_idx[p]][c_hway[p]] = CNT'(cnt_q[c_idx[p]][c_hway[p]] - CNT'(1));
                end
            end
        end
`ifdef BTB_FLUSH_EN
        if (in_sweep) begin
            valid_d[sweep_q] = '0;
        end
`endif
    end

    // Lookup against pre-update contents
    always_comb begin
        target_valid_d = '0;
        target_addr_d  = '0;
        for (int f = 0; f < FETCH; f++) begin
            l_idx[f] = btb_addr[f*ADDR+2 +: IDX_W];
            l_tag[f] = btb_addr[f*ADDR+2+IDX_W +: TAG_W];
            for (int w = 0; w < WAY; w++) begin
                if (valid_q[l_idx[f]][w] && (tag_q[l_idx[f]][w] == l_tag[f])) begin
                    target_valid_d[f]             = cnt_q[l_idx[f]][w][CNT-1];
                    target_addr_d[f*ADDR +: ADDR] = tgt_q[l_idx[f]][w];
                end
            end
            if (hide_lookup) begin
                target_valid_d[f] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
                for (int w = 0; w < WAY; w++) begin
                    tag_q[s][w] <= '0;
                    tgt_q[s][w] <= '0;
                    cnt_q[s][w] <= '0;
                end
            end
            target_valid_q <= '0;
            target_addr_q  <= '0;
        end else begin
            valid_q        <= valid_d;
            tag_q          <= tag_d;
            tgt_q          <= tgt_d;
            cnt_q          <= cnt_d;
            rr_q           <= rr_d;
            target_valid_q <= target_valid_d;
            target_addr_q  <= target_addr_d;
        end
    end

    assign target_valid = target_valid_q;
    assign target_addr  = target_addr_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc with two lookup and two commit ports; sweep checks when BTB_FLUSH_EN is set.
module tb_btb_assoc;

    localparam int unsigned ADDR     = 32;
    localparam int unsigned FETCH    = 2;
    localparam int unsigned SIMBRCOM = 2;

    logic                     clk = 1'b0;
    logic                     reset_;
    logic [FETCH*ADDR-1:0]    btb_addr;
    logic [FETCH-1:0]         target_valid;
    logic [FETCH*ADDR-1:0]    target_addr;
    logic [SIMBRCOM-1:0]      pc_chg_com_;
    logic [SIMBRCOM-1:0]      chg_taken_;
    logic [SIMBRCOM*ADDR-1:0] com_addr;
    logic [SIMBRCOM*ADDR-1:0] com_tar_addr;
`ifdef BTB_FLUSH_EN
    logic                     flush_;
    logic                     flush_busy;
`endif

    btb_assoc #(
        .ADDR(ADDR), .BTB_D(32), .WAY(2), .FETCH(FETCH), .SIMBRCOM(SIMBRCOM), .CNT(2)
    ) dut (
        .clk(clk),
        .reset_(reset_),
        .btb_addr(btb_addr),
        .target_valid(target_valid),
        .target_addr(target_addr),
        .pc_chg_com_(pc_chg_com_),
        .chg_taken_(chg_taken_),
        .com_addr(com_addr),
        .com_tar_addr(com_tar_addr)
`ifdef BTB_FLUSH_EN
        ,
        .flush_(flush_),
        .flush_busy(flush_busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [63:0] a;
        logic        chk_a;
        logic        b;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // 0 = no commit, 1 = taken, 2 = not-taken; expected port-0 valid is the pre-update counter MSB
    int         cnt_kind [11] = '{2, 2, 2, 1, 1, 1, 1, 2, 0, 2, 0};
    logic [0:10] cnt_expv = 11'b10000111110;

    task automatic push(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic chk_a, input logic b, input string nm);
        exp_t e;
        e.v = v; e.a = {a1, a0}; e.chk_a = chk_a; e.b = b; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic set_in(input logic [1:0] cv, input logic [1:0] tk,
                          input logic [31:0] ca0, input logic [31:0] ct0,
                          input logic [31:0] ca1, input logic [31:0] ct1,
                          input logic [31:0] la0, input logic [31:0] la1);
        pc_chg_com_  = ~cv;
        chg_taken_   = ~tk;
        com_addr     = {ca1, ca0};
        com_tar_addr = {ct1, ct0};
        btb_addr     = {la1, la0};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic busy_obs;
        set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'hdeadbe74, 0);
`ifdef BTB_FLUSH_EN
        flush_ = 1'b1;
`endif
        reset_ = 1'b1;
        #2 reset_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        busy_obs = 1'b0;
`ifdef BTB_FLUSH_EN
        busy_obs = flush_busy;
`endif
        n_vec++;
        if (target_valid !== 2'b00 || target_addr !== 64'h0 || busy_obs !== 1'b0) begin
            n_miss++;
            $display("FAIL reset: got valid=%b addr=%h busy=%b, want 0/0/0",
                     target_valid, target_addr, busy_obs);
        end
        reset_ = 1'b1;
    endtask

    task automatic test_train_lookup;
        exp_t e;
        set_in(2'b01, 2'b01, 32'hdeadbe74, 32'hcafecafe, 0, 0, 32'hdeadbe74, 32'hdeadbe70);
        push(2'b00, 0, 0, 1'b1, 1'b0, "train_same_cycle");
        tick();
        e = exp_q.pop_front(); n_vec++;
        if (target_valid !== e.v || target_addr !== e.a) begin
            n_miss++;
            $display("FAIL %s: got valid=%b addr=%h, want valid=%b addr=%h", e.nm, target_valid, target_addr, e.v, e.a);
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'hdeadbe74, 32'hdeadbe70);
                push(2'b01, 32'hcafecafe, 0, 1'b1, 1'b0, "lookup_hit_p0");
            end else begin
                set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'hdeadbe70, 32'hdeadbe74);
                push(2'b10, 0, 32'hcafecafe, 1'b1, 1'b0, "lookup_hit_p1");
            end
            tick();
            e = exp_q.pop_front(); n_vec++;
            if (target_valid !== e.v || target_addr !== e.a) begin
                n_miss++;
                $display("FAIL %s: got valid=%b addr=%h, want valid=%b addr=%h", e.nm, target_valid, target_addr, e.v, e.a);
            end
        end
    endtask

    task automatic test_counter;
        exp_t e;
        logic [1:0] cv, tk;
        for (int i = 0; i < 11; i++) begin
            cv = (cnt_kind[i] != 0) ? 2'b01 : 2'b00;
            tk = (cnt_kind[i] == 1) ? 2'b01 : 2'b00;
            set_in(cv, tk, 32'hdeadbe74, 32'hcafecafe, 0, 0, 32'hdeadbe74, 32'hdeadbe70);
            push({1'b0, cnt_expv[i]}, 32'hcafecafe, 0, 1'b1, 1'b0, $sformatf("counter_step%0d", i));
            tick();
            e = exp_q.pop_front(); n_vec++;
            if (target_valid !== e.v || target_addr !== e.a) begin
                n_miss++;
                $display("FAIL %s: got valid=%b addr=%h, want valid=%b addr=%h", e.nm, target_valid, target_addr, e.v, e.a);
            end
        end
    endtask

    task automatic test_replace;
        exp_t e;
        logic [31:0] ca [6] = '{32'h0000100c, 32'h0000200c, 32'h0000300c, 32'h0000400c, 0, 0};
        logic [31:0] ct [6] = '{32'h100, 32'h200, 32'h300, 32'h400, 0, 0};
        logic [1:0]  ev [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11};
        logic [31:0] e0 [6] = '{0, 32'h100, 32'h100, 0, 0, 32'h300};
        logic [31:0] e1 [6] = '{0, 0, 32'h200, 32'h200, 0, 32'h400};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_in(2'b01, 2'b01, ca[i], ct[i], 0, 0, 32'h0000100c, 32'h0000200c);
            else if (i == 4) set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'h0000100c, 32'h0000200c);
            else set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'h0000300c, 32'h0000400c);
            push(ev[i], e0[i], e1[i], 1'b1, 1'b0, $sformatf("replace_step%0d", i));
            tick();
            e = exp_q.pop_front(); n_vec++;
            if (target_valid !== e.v || target_addr !== e.a) begin
                n_miss++;
                $display("FAIL %s: got valid=%b addr=%h, want valid=%b addr=%h", e.nm, target_valid, target_addr, e.v, e.a);
            end
        end
    endtask

    task automatic test_ports;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    set_in(2'b11, 2'b11, 32'h00011014, 32'haaaa0000, 32'h00022014, 32'hbbbb0000,
                           32'h00011014, 32'h00022014);
                    push(2'b00, 0, 0, 1'b1, 1'b0, "ports_same_set_pre");
                end
                1: begin
                    set_in(2'b11, 2'b11, 32'h00033018, 32'hcccc0000, 32'h0004401c, 32'hdddd0000,
                           32'h00011014, 32'h00022014);
                    push(2'b01, 32'haaaa0000, 0, 1'b1, 1'b0, "ports_same_set_p0_wins");
                end
                2: begin
                    set_in(2'b10, 2'b11, 32'h00055020, 32'h11110000, 32'h00066020, 32'heeee0000,
                           32'h00033018, 32'h0004401c);
                    push(2'b11, 32'hcccc0000, 32'hdddd0000, 1'b1, 1'b0, "ports_diff_sets_both");
                end
                default: begin
                    set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'h00055020, 32'h00066020);
                    push(2'b10, 0, 32'heeee0000, 1'b1, 1'b0, "ports_idle_p0_no_block");
                end
            endcase
            tick();
            e = exp_q.pop_front(); n_vec++;
            if (target_valid !== e.v || target_addr !== e.a) begin
                n_miss++;
                $display("FAIL %s: got valid=%b addr=%h, want valid=%b addr=%h", e.nm, target_valid, target_addr, e.v, e.a);
            end
        end
    endtask

    task automatic test_same_cycle;
        exp_t e;
        set_in(2'b01, 2'b01, 32'h00001000, 32'h12345678, 0, 0, 32'h00001000, 32'hdeadbe74);
        push(2'b00, 0, 32'hcafecafe, 1'b1, 1'b0, "same_cycle_miss");
        tick();
        e = exp_q.pop_front(); n_vec++;
        if (target_valid !== e.v || target_addr !== e.a) begin
            n_miss++;
            $display("FAIL %s: got valid=%b addr=%h, want valid=%b addr=%h", e.nm, target_valid, target_addr, e.v, e.a);
        end
        set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'h00001000, 32'hdeadbe74);
        push(2'b01, 32'h12345678, 32'hcafecafe, 1'b1, 1'b0, "same_cycle_next_hit");
        tick();
        e = exp_q.pop_front(); n_vec++;
        if (target_valid !== e.v || target_addr !== e.a) begin
            n_miss++;
            $display("FAIL %s: got valid=%b addr=%h, want valid=%b addr=%h", e.nm, target_valid, target_addr, e.v, e.a);
        end
    endtask

`ifdef BTB_FLUSH_EN
    task automatic test_flush;
        exp_t e;
        for (int i = 0; i < 21; i++) begin
            flush_ = !(i == 0 || i == 5);
            if (i == 3 || i == 19)
                set_in(2'b01, 2'b01, 32'h00077024, 32'h99990000, 0, 0, 32'h00001000, 32'hdeadbe74);
            else if (i == 17)
                set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'h00077024, 32'h00001000);
            else if (i == 20)
                set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'h00077024, 32'h0000300c);
            else
                set_in(2'b00, 2'b00, 0, 0, 0, 0, 32'h00001000, 32'hdeadbe74);
            if (i <= 16)      push(2'b00, 0, 0, 1'b0, (i <= 15), $sformatf("sweep_cycle%0d", i));
            else if (i == 20) push(2'b01, 32'h99990000, 0, 1'b1, 1'b0, "post_sweep_retrain");
            else              push(2'b00, 0, 0, 1'b1, 1'b0, $sformatf("post_sweep_miss%0d", i));
            tick();
            e = exp_q.pop_front(); n_vec++;
            if (target_valid !== e.v || (e.chk_a && target_addr !== e.a) || flush_busy !== e.b) begin
                n_miss++;
                $display("FAIL %s: got valid=%b addr=%h busy=%b, want valid=%b addr=%h busy=%b",
                         e.nm, target_valid, target_addr, flush_busy, e.v, e.a, e.b);
            end
        end
        flush_ = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_train_lookup();
        test_counter();
        test_replace();
        test_ports();
        test_same_cycle();
`ifdef BTB_FLUSH_EN
        test_flush();
`endif
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
